// File: rtl/prop_board_pkg.sv
// Shared board-level reset types and defaults for the Propeller reset path.
// Used by prop_reset_pulse; see that file for the PROP_RESET_RTS_LEVEL_EN option.
package prop_board_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLDOFF
  } rst_state_t;

  localparam int RST_SYNC_STAGES_DEF    = 2;
  localparam int RST_PULSE_CYCLES_DEF   = 16;
  localparam int RST_HOLDOFF_CYCLES_DEF = 8;

  localparam logic [7:0] RST_PULSE_COUNT_MAX = 8'hFF;

  // Counter must hold the larger of the two reload values.
  function automatic int rst_cnt_width(input int pulse_cycles, input int holdoff_cycles);
    int m;
    m = (pulse_cycles > holdoff_cycles) ? pulse_cycles : holdoff_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit, preset to RESET_VAL in reset
// so that the first cycles after reset release never show a false transition.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_nres,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clock or negedge i_nres) begin
    if (!i_nres) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/prop_reset_pulse.sv
// Reset-request conditioner: merges RTS (edge-coupled pulse), Prop Plug and button
// into one registered active-high request. Define PROP_RESET_RTS_LEVEL_EN for level-coupled RTS.
module prop_reset_pulse
  import prop_board_pkg::*;
#(
  parameter int SYNC_STAGES    = RST_SYNC_STAGES_DEF,
  parameter int PULSE_CYCLES   = RST_PULSE_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES = RST_HOLDOFF_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       nres,
  input  logic       rts_n,
  input  logic       plug_res_n,
  input  logic       button_n,
  input  logic       plug_sel,
  output logic       res_req,
  output logic       busy,
  output logic [7:0] pulse_count
);

  logic w_rts_s;
  logic w_plug_s;
  logic w_button_s;
  logic w_level_req;
  logic r_res_req;

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rts (
    .i_clock (clock),
    .i_nres  (nres),
    .i_d     (rts_n),
    .o_q     (w_rts_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_plug (
    .i_clock (clock),
    .i_nres  (nres),
    .i_d     (plug_res_n),
    .o_q     (w_plug_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_button (
    .i_clock (clock),
    .i_nres  (nres),
    .i_d     (button_n),
    .o_q     (w_button_s)
  );

  assign w_level_req = ~w_button_s | (plug_sel & ~w_plug_s);

`ifdef PROP_RESET_RTS_LEVEL_EN

  always_ff @(posedge clock or negedge nres) begin
    if (!nres) begin
      r_res_req <= 1'b1;
    end else begin
      r_res_req <= w_level_req | (~plug_sel & ~w_rts_s);
    end
  end

  assign busy        = 1'b0;
  assign pulse_count = 8'd0;

`else

  localparam int CNT_W = rst_cnt_width(PULSE_CYCLES, HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  rst_state_t       r_state;
  rst_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_pending;
  logic             w_pending_next;
  logic [7:0]       r_pcount;
  logic [7:0]       w_pcount_next;
  logic [7:0]       w_pcount_inc;
  logic             r_rts_prev;
  logic             w_rts_fall;

  // Edges are gated only at detection, so a pulse already running finishes.
  assign w_rts_fall   = r_rts_prev & ~w_rts_s & ~plug_sel;
  assign w_pcount_inc = (r_pcount == RST_PULSE_COUNT_MAX) ? r_pcount : r_pcount + 8'd1;

  always_ff @(posedge clock or negedge nres) begin
    if (!nres) begin
      r_state    <= IDLE;
      r_cnt      <= CNT_ZERO;
      r_pending  <= 1'b0;
      r_pcount   <= 8'd0;
      r_rts_prev <= 1'b1;
      r_res_req  <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_pending  <= w_pending_next;
      r_pcount   <= w_pcount_next;
      r_rts_prev <= w_rts_s;
      r_res_req  <= (w_state_next == PULSE) | w_level_req;
    end
  end

  // An edge seen during HOLDOFF is queued and launches a new pulse once HOLDOFF ends.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pending_next = r_pending;
    w_pcount_next  = r_pcount;
    unique case (r_state)
      IDLE: begin
        if (w_rts_fall) begin
          w_state_next  = PULSE;
          w_cnt_next    = PULSE_LOAD;
          w_pcount_next = w_pcount_inc;
        end
      end
      PULSE: begin
        if (w_rts_fall) begin
          w_cnt_next = PULSE_LOAD;
        end else if (r_cnt == CNT_ZERO) begin
          if (HOLDOFF_CYCLES == 0) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = HOLDOFF;
            w_cnt_next   = HOLD_LOAD;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      HOLDOFF: begin
        if (r_cnt == CNT_ZERO) begin
          if (r_pending | w_rts_fall) begin
            w_state_next   = PULSE;
            w_cnt_next     = PULSE_LOAD;
            w_pending_next = 1'b0;
            w_pcount_next  = w_pcount_inc;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
          if (w_rts_fall) begin
            w_pending_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_cnt_next     = CNT_ZERO;
        w_pending_next = 1'b0;
      end
    endcase
  end

  assign busy        = (r_state != IDLE);
  assign pulse_count = r_pcount;

`endif

  assign res_req = r_res_req;

endmodule

// File: tb/tb_prop_reset_pulse.sv
// Directed self-checking bench for prop_reset_pulse (SYNC_STAGES=2, PULSE_CYCLES=4,
// HOLDOFF_CYCLES=3); edge numbering below counts clock edges after each stimulus change.
module tb_prop_reset_pulse;

  logic       clock;
  logic       nres;
  logic       rts_n;
  logic       plug_res_n;
  logic       button_n;
  logic       plug_sel;
  logic       res_req;
  logic       busy;
  logic [7:0] pulse_count;

  int checks = 0;
  int errors = 0;
  int expCount = 0;

  prop_reset_pulse #(
    .SYNC_STAGES    (2),
    .PULSE_CYCLES   (4),
    .HOLDOFF_CYCLES (3)
  ) dut (
    .clock       (clock),
    .nres        (nres),
    .rts_n       (rts_n),
    .plug_res_n  (plug_res_n),
    .button_n    (button_n),
    .plug_sel    (plug_sel),
    .res_req     (res_req),
    .busy        (busy),
    .pulse_count (pulse_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rts, input logic plug, input logic button, input logic sel);
    rts_n      = rts;
    plug_res_n = plug;
    button_n   = button;
    plug_sel   = sel;
  endtask

  task automatic checkOutput(input string tag, input logic expRes, input logic expBusy);
    checks++;
    assert (res_req === expRes) else begin
      errors++;
      $error("[TB] FAIL %s res_req: observed %b expected %b", tag, res_req, expRes);
    end
    checks++;
    assert (busy === expBusy) else begin
      errors++;
      $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, expBusy);
    end
  endtask

  task automatic checkCount(input string tag, input int expected);
    checks++;
    assert (pulse_count === 8'(expected)) else begin
      errors++;
      $error("[TB] FAIL %s pulse_count: observed %0d expected %0d", tag, pulse_count, expected);
    end
  endtask

  initial begin
    nres = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

    // Reset holds the request high and clears everything else.
    step(3);
    checkOutput("in_reset", 1'b1, 1'b0);
    checkCount("in_reset", 0);
    nres = 1'b1;
    step(1);
    checkOutput("first_edge_after_reset", 1'b0, 1'b0);
    step(10);
    checkOutput("idle_after_reset", 1'b0, 1'b0);
    checkCount("idle_after_reset", 0);

    // Single RTS fall held low: pulse on edges 3..6, busy on edges 3..9.
    rts_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      checkOutput($sformatf("rts_single_e%0d", i), (i >= 3 && i <= 6), (i >= 3 && i <= 9));
    end
    expCount = 1;
    step(88);
    checkOutput("rts_held_low", 1'b0, 1'b0);
    checkCount("rts_single", expCount);
    rts_n = 1'b1;
    step(5);
    checkOutput("rts_rise_no_pulse", 1'b0, 1'b0);

    // Fall, rise after edge 2, fall after edge 5 lands in HOLDOFF and is queued.
    rts_n = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      step(1);
      checkOutput($sformatf("rts_queued_e%0d", i), (i >= 3 && i <= 6) || (i >= 10 && i <= 13),
                  (i >= 3 && i <= 16));
      if (i == 2) rts_n = 1'b1;
      if (i == 5) rts_n = 1'b0;
    end
    expCount = 3;
    checkCount("rts_queued", expCount);
    rts_n = 1'b1;
    step(5);

    // Plug path live: plug level for 20 cycles shifted by 3, RTS toggling ignored.
    plug_sel = 1'b1;
    step(2);
    plug_res_n = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      step(1);
      checkOutput($sformatf("plug_e%0d", i), (i >= 3 && i <= 22), 1'b0);
      if (i % 3 == 0 && i <= 18) rts_n = ~rts_n;
      if (i == 20) plug_res_n = 1'b1;
    end
    checkCount("plug_no_rts", expCount);
    step(4);
    plug_sel = 1'b0;

    // Plug input is ignored when the RTS path is selected.
    plug_res_n = 1'b0;
    step(6);
    checkOutput("plug_ignored", 1'b0, 1'b0);
    plug_res_n = 1'b1;
    step(4);

    // Button pressed after edge 1, released after edge 5: request high on edges 3..7.
    rts_n = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step(1);
      checkOutput($sformatf("button_e%0d", i), (i >= 3 && i <= 7), (i >= 3 && i <= 9));
      if (i == 1) button_n = 1'b0;
      if (i == 5) button_n = 1'b1;
    end
    expCount = 4;
    checkCount("button_pulse", expCount);
    rts_n = 1'b1;
    step(5);

    // Many spaced edges saturate the pulse counter.
    for (int n = 0; n < 300; n++) begin
      rts_n = 1'b0;
      step(10);
      rts_n = 1'b1;
      step(10);
    end
    checkCount("saturated", 255);
    checkOutput("after_saturation", 1'b0, 1'b0);

    // Asynchronous reset in the middle of a pulse.
    rts_n = 1'b0;
    step(4);
    checkOutput("mid_pulse", 1'b1, 1'b1);
    nres = 1'b0;
    #1;
    checkOutput("async_reset_mid_pulse", 1'b1, 1'b0);
    checkCount("async_reset_mid_pulse", 0);
    rts_n = 1'b1;
    step(2);
    nres = 1'b1;
    step(1);
    checkOutput("release_after_mid_reset", 1'b0, 1'b0);
    step(5);
    checkOutput("quiet_after_mid_reset", 1'b0, 1'b0);
    checkCount("quiet_after_mid_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
